mult_pipe4: RTL and testbench
=============================

Name: mult_pipe4

Overview:
- Parameterized integer multiplier, pipelined in four stages: A_width x B_width operands, A_width+B_width product.
- Supports unsigned and two's-complement operation, selected at run time.
- Used as the mantissa-multiply core of the 64-bit FP multiply datapath: 53x53 for fractA*fractB, then 106x53 for the second product.
- Full throughput (one new operand pair per clock), fixed latency, no handshake; the caller delay-matches its control/valid signals by the latency.

Parameters:
- A_width, 8, width of operand A in bits (>=2; 53 and 106 used in the datapath).
- B_width, 8, width of operand B in bits (>=2; 53 used in the datapath).

Ports:
- clk  input  1  clock, rising edge active.
- rst  input  1  reset, asynchronous, active-high.
- A  input  A_width  multiplicand.
- B  input  B_width  multiplier.
- TC  input  1  0 = A, B and PRODUCT unsigned; 1 = all two's complement.
- PRODUCT  output  A_width+B_width  registered product.

Behaviour:
- Reset and clock:
  - Reset is rst, asynchronous, active-high; clock is clk.
  - While rst=1, every pipeline register (data, partial sums, delayed TC) is 0, so PRODUCT=0.
  - Reset asserted mid-operation discards all in-flight products immediately.
  - After rst falls, PRODUCT stays 0 until the first post-reset operands have passed through the pipeline.
- Latency: exactly 3 rising clk edges.
  - Stage 0 is combinational from A/B/TC into register bank 1. Banks 2 and 3 follow.
  - PRODUCT is driven directly from bank 3, with no output logic after the register.
  - Operands applied before edge N appear on PRODUCT after edge N+2 and stay valid until after edge N+3.
- Throughput: a new A/B/TC every cycle; consecutive results emerge on consecutive cycles in order. No stall or enable.
- TC is sampled on the same edge as A/B and travels with its operands. Changing TC between cycles must never corrupt in-flight products.
- Arithmetic:
  - TC=0: PRODUCT = A*B, exact, unsigned, no truncation.
  - TC=1: PRODUCT = signed(A)*signed(B), exact two's complement, sign-extended to the full width.
  - PRODUCT never overflows: the full A_width+B_width result is always produced.
- Required structure: a genuine distributed pipeline.
  - Stage 0 generates partial products; B is split into roughly equal slices, with sign handling for TC=1.
  - Stage 1 registers the slice products.
  - Stage 2 sums them into two partial sums (carry-save or pairwise add).
  - Stage 3 does the final carry-propagate add and registers.
  - A single behavioural multiply followed by three delay registers is not acceptable.
- No X propagation: with known inputs, PRODUCT is fully known from the first edge after reset deasserts.
- Boundary conditions:
  - A=0 or B=0 gives 0.
  - Unsigned all-ones gives (2^A_width-1)*(2^B_width-1).
  - TC=1 with both operands at most-negative gives +2^(A_width+B_width-2).
  - Mixed TC across back-to-back cycles gives each result under its own TC.

Test Plan:
- 8x8, TC=0: A=0xFF, B=0xFF applied at cycle 0 -> PRODUCT=0xFE01 after the 3rd edge. Cycles 1-2 show the prior/reset value 0x0000.
- 8x8, TC=1: A=0xFF (-1), B=0x02 -> 0xFFFE. Next cycle A=0x80, B=0x80 -> 0x4000. Next cycle TC=0, A=0x80, B=0x80 -> 0x4000. Next cycle TC=0, A=0xFF, B=0x02 -> 0x01FE. All four results appear on consecutive cycles.
- Streaming 1000 random operand pairs with random TC, one per cycle: every PRODUCT matches the golden model delayed by exactly 3 cycles.
- Reset mid-stream: assert rst asynchronously between edges with 3 products in flight -> PRODUCT drops to 0 immediately. Deassert with A=3, B=5, TC=0 held -> 0 for two edges, 15 after the 3rd.
- 53x53, TC=0: A=B=2^53-1 -> (2^53-1)^2 = 2^106 - 2^54 + 1. Then A=2^52, B=2^52 -> 2^104 (bit 104 set only).
- 106x53, TC=0: A=2^106-1, B=2^53-1 -> full 159-bit exact product, MSB bit 158 = 1.

Source files
------------

// File: rtl/mult_pipe4.sv
// Four-stage pipelined integer multiplier, unsigned or two's complement selected per operand pair.
// B is sliced across lanes; each lane registers one slice product, lanes are folded into two sums, then added.

module mult_pipe4_lane #(
  parameter int AW = 8,
  parameter int SW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW:0]     a_ext,
  input  logic [SW:0]     b_slc,
  output logic [AW+SW+1:0] pp
);
  localparam int PPW = AW + SW + 2;

  logic signed [PPW-1:0] a_s, b_s;

  assign a_s = PPW'($signed(a_ext));
  assign b_s = PPW'($signed(b_slc));

  always_ff @(posedge clk or posedge rst)
    if (rst) pp <= '0;
    else     pp <= a_s * b_s;
endmodule

module mult_pipe4 #(
  parameter int A_width = 8,
  parameter int B_width = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [A_width-1:0]         A,
  input  logic [B_width-1:0]         B,
  input  logic                       TC,
  output logic [A_width+B_width-1:0] PRODUCT
);
  localparam int NUM_LANES = (B_width >= 8) ? 4 : 2;
  localparam int SW        = (B_width + NUM_LANES - 1) / NUM_LANES;
  localparam int BP        = NUM_LANES * SW;
  localparam int PW        = A_width + B_width;
  localparam int PPW       = A_width + SW + 2;

  logic                           s_a, s_b;
  logic [A_width:0]               a_ext;
  logic [BP-1:0]                  b_pad;
  logic [NUM_LANES-1:0][PPW-1:0]  pp;
  logic [PW-1:0]                  sum0, sum1, ps0, ps1;

  // TC is fully consumed here: operands become signed values one bit wider,
  // so nothing downstream needs to know the mode.
  assign s_a   = TC & A[A_width-1];
  assign s_b   = TC & B[B_width-1];
  assign a_ext = {s_a, A};
  assign b_pad = BP'($signed({s_b, B}));

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [SW:0] b_slc;
    // Only the top slice carries B's sign; lower slices are plain magnitudes.
    assign b_slc = {(i == NUM_LANES-1) ? s_b : 1'b0, b_pad[i*SW +: SW]};

    mult_pipe4_lane #(.AW(A_width), .SW(SW)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .a_ext (a_ext),
      .b_slc (b_slc),
      .pp    (pp[i])
    );
  end

  // Modulo-2^PW accumulation is exact because the true product always fits in PW bits.
  always_comb begin
    sum0 = '0;
    sum1 = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (i % 2 == 0) sum0 = sum0 + (PW'($signed(pp[i])) << (i*SW));
      else            sum1 = sum1 + (PW'($signed(pp[i])) << (i*SW));
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ps0 <= '0;
      ps1 <= '0;
    end else begin
      ps0 <= sum0;
      ps1 <= sum1;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) PRODUCT <= '0;
    else     PRODUCT <= ps0 + ps1;
endmodule

// File: tb/tb_mult_pipe4.sv
// Scoreboard bench for mult_pipe4 at 8x8, 53x53 and 106x53, all driven in lockstep.
module tb_mult_pipe4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]   a8,   b8;   logic tc8;   logic [15:0]  p8;
  logic [52:0]  a53,  b53;  logic tc53;  logic [105:0] p53;
  logic [105:0] a106;
  logic [52:0]  b106;       logic tc106; logic [158:0] p106;

  mult_pipe4 #(.A_width(8),   .B_width(8))  d8   (.clk(clk), .rst(rst), .A(a8),   .B(b8),   .TC(tc8),   .PRODUCT(p8));
  mult_pipe4 #(.A_width(53),  .B_width(53)) d53  (.clk(clk), .rst(rst), .A(a53),  .B(b53),  .TC(tc53),  .PRODUCT(p53));
  mult_pipe4 #(.A_width(106), .B_width(53)) d106 (.clk(clk), .rst(rst), .A(a106), .B(b106), .TC(tc106), .PRODUCT(p106));

  int errors = 0;
  int checks = 0;
  logic [159:0] q8[$], q53[$], q106[$];
  bit fresh = 1'b0;

  function automatic logic [159:0] mask(int w);
    logic [159:0] m;
    m = '1;
    return m >> (160 - w);
  endfunction

  // Golden product: sign-extend to 160 bits, multiply mod 2^160, keep the low aw+bw bits.
  function automatic logic [159:0] gold(logic [159:0] a, int aw, logic [159:0] b, int bw, bit tc);
    logic [159:0] sa, sb;
    sa = a & mask(aw);
    sb = b & mask(bw);
    if (tc && sa[aw-1]) sa = sa | ~mask(aw);
    if (tc && sb[bw-1]) sb = sb | ~mask(bw);
    return (sa * sb) & mask(aw + bw);
  endfunction

  function automatic logic [159:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic step(input string tag);
    q8.push_back(gold(160'(a8), 8, 160'(b8), 8, tc8));
    q53.push_back(gold(160'(a53), 53, 160'(b53), 53, tc53));
    q106.push_back(gold(160'(a106), 106, 160'(b106), 53, tc106));
    @(posedge clk);
    #1;
    if (q8.size() == 3) begin
      chk({tag, "_p8"},   160'(p8),   q8.pop_front());
      chk({tag, "_p53"},  160'(p53),  q53.pop_front());
      chk({tag, "_p106"}, 160'(p106), q106.pop_front());
      fresh = 1'b0;
    end else if (fresh) begin
      chk({tag, "_fill8"},   160'(p8),   160'd0);
      chk({tag, "_fill53"},  160'(p53),  160'd0);
      chk({tag, "_fill106"}, 160'(p106), 160'd0);
    end
    @(negedge clk);
  endtask

  task automatic zero_inputs();
    a8 = '0; b8 = '0; tc8 = 1'b0;
    a53 = '0; b53 = '0; tc53 = 1'b0;
    a106 = '0; b106 = '0; tc106 = 1'b0;
  endtask

  logic [7:0]   da8  [5] = '{8'hFF, 8'hFF, 8'h80, 8'h80, 8'hFF};
  logic [7:0]   db8  [5] = '{8'hFF, 8'h02, 8'h80, 8'h80, 8'h02};
  bit           dt8  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  bit           dt53 [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  bit           dt106[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    logic [52:0]  ones53, top53;
    logic [105:0] ones106, top106;
    logic [159:0] r;
    ones53  = '1;
    top53   = 53'd1 << 52;
    ones106 = '1;
    top106  = 106'd1 << 105;

    zero_inputs();
    #12;
    chk("reset_p8",   160'(p8),   160'd0);
    chk("reset_p53",  160'(p53),  160'd0);
    chk("reset_p106", 160'(p106), 160'd0);

    @(negedge clk);
    rst = 1'b0;
    fresh = 1'b1;

    for (int i = 0; i < 5; i++) begin
      a8 = da8[i]; b8 = db8[i]; tc8 = dt8[i];
      tc53 = dt53[i];
      tc106 = dt106[i];
      case (i)
        0: begin a53 = ones53; b53 = ones53; a106 = ones106; b106 = ones53; end
        1: begin a53 = top53;  b53 = top53;  a106 = top106;  b106 = top53;  end
        2: begin a53 = top53;  b53 = top53;  a106 = ones106; b106 = ones53; end
        3: begin a53 = ones53; b53 = 53'd1;  a106 = '0;      b106 = ones53; end
        default: begin a53 = '0; b53 = ones53; a106 = ones106; b106 = 53'd2; end
      endcase
      step("dir");
    end
    zero_inputs();
    for (int i = 0; i < 3; i++) step("flush");

    for (int i = 0; i < 1000; i++) begin
      r = rnd(); a8   = 8'(r);   b8   = 8'(r >> 8);   tc8   = r[16];
      r = rnd(); a53  = 53'(r);  b53  = 53'(r >> 53); tc53  = r[106];
      r = rnd(); a106 = 106'(r); b106 = 53'(r >> 106); tc106 = r[159];
      step("rand");
    end

    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_p8",   160'(p8),   160'd0);
    chk("rst_async_p53",  160'(p53),  160'd0);
    chk("rst_async_p106", 160'(p106), 160'd0);
    q8.delete(); q53.delete(); q106.delete();
    @(negedge clk);
    zero_inputs();
    a8 = 8'd3; b8 = 8'd5;
    @(negedge clk);
    rst = 1'b0;
    fresh = 1'b1;
    for (int i = 0; i < 4; i++) step("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
